// File: rtl/o_serdes_tx_if.sv
// Parallel-side handshake and serial-side outputs of the output serializer.
// The master side (fabric) drives the word, its valid strobe and the enable.
// The slave side (serializer) returns ready, the serial bit and status flags.
interface o_serdes_tx_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] d;
  logic             data_valid;
  logic             load_ready;
  logic             q;
  logic             word_start;
  logic             underrun;

  modport master (
    output en, d, data_valid,
    input  load_ready, q, word_start, underrun
  );

  modport slave (
    input  en, d, data_valid,
    output load_ready, q, word_start, underrun
  );
endinterface

// File: rtl/o_serdes_tx.sv
// Output serializer: accepts one parallel word into a single-entry holding
// buffer and shifts words out one bit per bit clock on a registered output.
// Words stream back-to-back while the buffer is refilled in time; otherwise
// the line returns to IDLE_BIT and a one-cycle underrun pulse is raised.
module o_serdes_tx #(
  parameter int   WIDTH     = 4,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic       clk_in,
  input  logic       tx_rst,
  o_serdes_tx_if.slave bus
);

  if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
    $error("%m: illegal WIDTH=%0d, legal range is 3 to 10", WIDTH);
  end

  if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_order
    $error("%m: illegal MSB_FIRST=%0d, must be 0 or 1", MSB_FIRST);
  end

  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [WIDTH-1:0] shift_reg, shift_n, shifted;
  logic [WIDTH-1:0] buffer, buffer_n;
  logic             full, full_n;
  logic             paused, paused_n;
  logic             q_r, q_n;
  logic             ws_r, ws_n;
  logic             ur_r, ur_n;
  logic             lr_r;
  logic             accept;

  // The bit currently on the line always sits at the outgoing end of
  // shift_reg, so a paused word can re-drive it without any indexing.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  assign shifted = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
  assign accept  = bus.data_valid && lr_r;

  // Next-state logic: handshake capture, pause/resume and the shift FSM.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_n  = shift_reg;
    buffer_n = buffer;
    full_n   = full;
    paused_n = paused;
    q_n      = q_r;
    ws_n     = 1'b0;
    ur_n     = 1'b0;

    if (accept) begin
      buffer_n = bus.d;
      full_n   = 1'b1;
    end

    if (!bus.en) begin
      q_n      = IDLE_BIT;
      paused_n = 1'b1;
    end else if (paused && state == SHIFT) begin
      q_n      = first_bit(shift_reg);
      ws_n     = (cnt == 4'd0);
      paused_n = 1'b0;
    end else begin
      paused_n = 1'b0;
      unique case (state)
        IDLE: begin
          if (full) begin
            state_n = SHIFT;
            shift_n = buffer;
            full_n  = 1'b0;
            q_n     = first_bit(buffer);
            ws_n    = 1'b1;
            cnt_n   = 4'd0;
          end else begin
            q_n = IDLE_BIT;
          end
        end
        SHIFT: begin
          if (cnt < LAST) begin
            shift_n = shifted;
            q_n     = first_bit(shifted);
            cnt_n   = cnt + 4'd1;
          end else if (full) begin
            shift_n = buffer;
            full_n  = 1'b0;
            q_n     = first_bit(buffer);
            ws_n    = 1'b1;
            cnt_n   = 4'd0;
          end else begin
            state_n = IDLE;
            q_n     = IDLE_BIT;
            ur_n    = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          q_n     = IDLE_BIT;
        end
      endcase
    end
  end

  // State register; reset discards the word in flight and any buffered word.
  always_ff @(posedge clk_in) begin
    if (tx_rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      shift_reg <= '0;
      buffer    <= '0;
      full      <= 1'b0;
      paused    <= 1'b0;
      q_r       <= IDLE_BIT;
      ws_r      <= 1'b0;
      ur_r      <= 1'b0;
      lr_r      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shift_reg <= shift_n;
      buffer    <= buffer_n;
      full      <= full_n;
      paused    <= paused_n;
      q_r       <= q_n;
      ws_r      <= ws_n;
      ur_r      <= ur_n;
      lr_r      <= !full_n;
    end
  end

  assign bus.q          = q_r;
  assign bus.word_start = ws_r;
  assign bus.underrun   = ur_r;
  assign bus.load_ready = lr_r;

endmodule
